nrzi_unstuff_rx: RTL
====================

Name: nrzi_unstuff_rx

Overview:
Receive-side counterpart of the NRZI transmit path on the USB link.
- Samples the raw line one bit per clk and NRZI-decodes it (no transition = 1, transition = 0).
- Locks onto SYNC, removes stuffed bits and detects stuffing errors.
- Frames the packet on SE0 (EOP).
- Feeds the downstream packet decoder a stream of valid data bits with start/end pulses.

Parameters:
SYNC_LEN, 8, SYNC length in bits; decoded form is SYNC_LEN-1 zeros followed by a single 1.
STUFF_RUN, 6, run of decoded 1s after which the next bit is a stuffed 0.
CNT_W, 10, width of bit_cnt.

Ports:
clk  input  1  system clock, one line bit per cycle
rst_L  input  1  asynchronous, active-low reset
inb  input  1  raw line bit (1 = J, 0 = K); ignored while se0=1
se0  input  1  line is in single-ended zero this cycle
en  input  1  receiver armed; 0 forces IDLE
outb  output  1  decoded, unstuffed data bit
out_valid  output  1  outb holds a data bit this cycle
pkt_start  output  1  one-cycle pulse: SYNC accepted
pkt_end  output  1  one-cycle pulse: EOP seen on a good packet
stuff_err  output  1  one-cycle pulse: bit-stuff violation
bit_cnt  output  CNT_W  count of data bits in current/last packet

Behaviour:
- Reset values: outb=0, out_valid=0, pkt_start=0, pkt_end=0, stuff_err=0, bit_cnt=0, state=IDLE, prev line reg=1 (J), zero/ones counters=0.
- Decode: d = (inb == prev). prev <= inb every cycle se0=0; prev <= 1 while se0=1.
- All outputs are registered. Latency is 1 cycle from the inb sample to outb/out_valid and the pulses.
- IDLE:
  - d=0 -> SYNC with zcnt=1.
  - se0 -> stay IDLE (ignored).
- SYNC:
  - d=0 -> zcnt++ (saturating).
  - d=1 with zcnt in the accepted range -> DATA, pkt_start=1, bit_cnt<=0, ones<=0.
  - d=1 with zcnt outside the range -> IDLE.
  - se0 -> IDLE.
- DATA, priority order:
  1. se0 -> EOP, pkt_end=1. Any pending stuffed bit is discarded.
  2. ones==STUFF_RUN and d=0 -> stuffed bit dropped (out_valid=0), ones<=0.
  3. ones==STUFF_RUN and d=1 -> stuff_err=1, go to ERR, no output.
  4. Otherwise -> outb=d, out_valid=1, bit_cnt++. ones<=d ? ones+1 : 0.
- ERR: no outputs. se0 -> EOP with no pkt_end.
- EOP: wait for se0=0, then -> IDLE. prev is already 1.
- en=0 in any state:
  - Synchronous return to IDLE; counters cleared.
  - No pkt_end for an aborted packet.
  - bit_cnt holds.
- bit_cnt saturates at all-ones. It holds its value after pkt_end until the next pkt_start.
- Pulses (pkt_start, pkt_end, stuff_err) are never asserted together.
- out_valid is never asserted in the same cycle as pkt_end.
- Asserting rst_L mid-packet returns everything to reset values immediately. The next packet needs a full SYNC.

Optional Feature:
NRZI_RX_STRICT_SYNC_EN
- Defined: SYNC is accepted only if zcnt == SYNC_LEN-1 exactly.
- Undefined: SYNC is accepted for zcnt in [SYNC_LEN-5, SYNC_LEN-1]. For the default this is 3..7, which tolerates up to 4 sync bits dropped by hubs.
- Longer zero runs are rejected in both builds.

Test Plan:
1. Clean packet:
   - Stimulus: idle J x4; line for SYNC KJKJKJKK; NRZI-encoded data byte 0xA5 (LSB first); SE0 x2; J.
   - Response: pkt_start once, then 8 out_valid bits 1,0,1,0,0,1,0,1, then pkt_end; bit_cnt=8; stuff_err never.
2. Stuffing:
   - Stimulus: data 0xFF with a stuffed 0 after the sixth 1.
   - Response: 8 ones output, one out_valid gap cycle, bit_cnt=8, no stuff_err.
3. Stuff violation:
   - Stimulus: seven consecutive decoded 1s in DATA.
   - Response: stuff_err pulses exactly once; no out_valid after the sixth 1; SE0 gives no pkt_end; IDLE after J.
4. Short SYNC:
   - Stimulus: 5 zeros then 1.
   - Response: with NRZI_RX_STRICT_SYNC_EN, no pkt_start. Without it, pkt_start. Both builds: 2 zeros then 1 -> no pkt_start.
5. Abort:
   - Stimulus: en=0 mid-DATA after 4 bits.
   - Response: IDLE next cycle, no pkt_end, bit_cnt=4; next clean packet is received normally.
6. Reset:
   - Stimulus: rst_L low mid-packet.
   - Response: all outputs 0 asynchronously; after release, the remainder of the old packet yields no pkt_start.

Source files
------------

// File: rtl/nrzi_unstuff_rx.sv
// USB receive front end: NRZI decode, SYNC lock, bit unstuffing and EOP framing.
// Define NRZI_RX_STRICT_SYNC_EN to accept only a full-length SYNC.
module nrzi_unstuff_rx #(
   parameter int SYNC_LEN  = 8,
   parameter int STUFF_RUN = 6,
   parameter int CNT_W     = 10
) (
   input  logic             clk,
   input  logic             rst_L,
   input  logic             inb,
   input  logic             se0,
   input  logic             en,
   output logic             outb,
   output logic             out_valid,
   output logic             pkt_start,
   output logic             pkt_end,
   output logic             stuff_err,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int ZW = $clog2(SYNC_LEN) + 1;
   localparam int OW = $clog2(STUFF_RUN + 1);
   localparam logic [ZW-1:0] Z_LAST = ZW'(SYNC_LEN - 1);
   localparam logic [ZW-1:0] Z_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_DATA = 3'd2,
      S_ERR  = 3'd3,
      S_EOP  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic             prev;
   logic [ZW-1:0]    zcnt, zcnt_nxt;
   logic [OW-1:0]    ones, ones_nxt;
   logic             d;
   logic             sync_ok;
   logic             stuff_full;
   logic [CNT_W-1:0] bit_cnt_inc;

   logic             outb_nxt, out_valid_nxt, pkt_start_nxt, pkt_end_nxt, stuff_err_nxt;
   logic [CNT_W-1:0] bit_cnt_nxt;

   // No line transition decodes as a 1.
   assign d          = (inb == prev);
   assign stuff_full = (ones == OW'(STUFF_RUN));
   assign bit_cnt_inc = (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;

`ifdef NRZI_RX_STRICT_SYNC_EN
   assign sync_ok = (zcnt == Z_LAST);
`else
   // Hubs may eat up to four leading SYNC bits.
   localparam logic [ZW-1:0] Z_FIRST = ZW'(SYNC_LEN - 5);
   assign sync_ok = (zcnt >= Z_FIRST) && (zcnt <= Z_LAST);
`endif

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state     <= S_IDLE;
         prev      <= 1'b1;
         zcnt      <= '0;
         ones      <= '0;
         outb      <= 1'b0;
         out_valid <= 1'b0;
         pkt_start <= 1'b0;
         pkt_end   <= 1'b0;
         stuff_err <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         prev      <= se0 ? 1'b1 : inb;
         zcnt      <= zcnt_nxt;
         ones      <= ones_nxt;
         outb      <= outb_nxt;
         out_valid <= out_valid_nxt;
         pkt_start <= pkt_start_nxt;
         pkt_end   <= pkt_end_nxt;
         stuff_err <= stuff_err_nxt;
         bit_cnt   <= bit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      zcnt_nxt  = zcnt;
      ones_nxt  = ones;
      if (!en) begin
         state_nxt = S_IDLE;
         zcnt_nxt  = '0;
         ones_nxt  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!se0 && !d) begin
                  state_nxt = S_SYNC;
                  zcnt_nxt  = ZW'(1);
               end
            end
            S_SYNC: begin
               if (se0) begin
                  state_nxt = S_IDLE;
                  zcnt_nxt  = '0;
               end else if (!d) begin
                  zcnt_nxt = (zcnt == Z_MAX) ? zcnt : zcnt + 1'b1;
               end else begin
                  state_nxt = sync_ok ? S_DATA : S_IDLE;
                  zcnt_nxt  = '0;
                  ones_nxt  = '0;
               end
            end
            S_DATA: begin
               if (se0) begin
                  state_nxt = S_EOP;
                  ones_nxt  = '0;
               end else if (stuff_full) begin
                  ones_nxt = '0;
                  if (d) state_nxt = S_ERR;
               end else begin
                  ones_nxt = d ? ones + 1'b1 : '0;
               end
            end
            S_ERR: begin
               if (se0) state_nxt = S_EOP;
            end
            S_EOP: begin
               if (!se0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      outb_nxt      = 1'b0;
      out_valid_nxt = 1'b0;
      pkt_start_nxt = 1'b0;
      pkt_end_nxt   = 1'b0;
      stuff_err_nxt = 1'b0;
      bit_cnt_nxt   = bit_cnt;
      if (en) begin
         case (state)
            S_SYNC: begin
               if (!se0 && d && sync_ok) begin
                  pkt_start_nxt = 1'b1;
                  bit_cnt_nxt   = '0;
               end
            end
            S_DATA: begin
               if (se0) begin
                  pkt_end_nxt = 1'b1;
               end else if (stuff_full) begin
                  stuff_err_nxt = d;
               end else begin
                  outb_nxt      = d;
                  out_valid_nxt = 1'b1;
                  bit_cnt_nxt   = bit_cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
